tag_cmp_arb: RTL and testbench

Parametrised arbiter and tag comparator for the set-associative data cache. It grants one of NR_PORTS requesters per cycle to the shared tag/data SRAMs, with fixed-priority or round-robin selection. One cycle after the grant it compares the winner's late tag against all ways. It returns a per-port response: hit vector, encoded way, selected line data and a multi-hit error flag. It sits between the cache controller ports and the way SRAMs, with single-cycle SRAM read latency.

---
 rtl/tag_cmp_arb_if.sv | 51 +++++
 rtl/tag_cmp_arb.sv | 149 ++++++++++++++
 tb/tb_tag_cmp_arb.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_cmp_arb_if.sv
// rtl/tag_cmp_arb_if.sv - requester and way-SRAM signal bundle for tag_cmp_arb
interface tag_cmp_arb_if #(
  parameter int NR_PORTS   = 3,
  parameter int NR_WAYS    = 8,
  parameter int ADDR_WIDTH = 64,
  parameter int TAG_WIDTH  = 44,
  parameter int DATA_WIDTH = 128,
  parameter int BE_WIDTH   = 16,
  parameter int CNT_WIDTH  = 8
);
  localparam int IDX_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

  logic [NR_PORTS-1:0][NR_WAYS-1:0]    req_i;
  logic [NR_PORTS-1:0]                 gnt_o;
  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0] addr_i;
  logic [NR_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
  logic [NR_PORTS-1:0]                 we_i;
  logic [NR_PORTS-1:0][BE_WIDTH-1:0]   be_i;
  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]  tag_i;

  logic [NR_WAYS-1:0]                  req_o;
  logic [ADDR_WIDTH-1:0]               addr_o;
  logic [DATA_WIDTH-1:0]               wdata_o;
  logic                                we_o;
  logic [BE_WIDTH-1:0]                 be_o;
  logic [NR_WAYS-1:0][TAG_WIDTH-1:0]   tag_rdata_i;
  logic [NR_WAYS-1:0]                  valid_rdata_i;
  logic [NR_WAYS-1:0][DATA_WIDTH-1:0]  data_rdata_i;

  logic [NR_PORTS-1:0]                 rvalid_o;
  logic [NR_WAYS-1:0]                  hit_way_o;
  logic                                hit_o;
  logic [IDX_W-1:0]                    hit_idx_o;
  logic [DATA_WIDTH-1:0]               rdata_o;
  logic                                multi_hit_o;
  logic [CNT_WIDTH-1:0]                multi_hit_cnt_o;

  modport slave (
    input  req_i, addr_i, wdata_i, we_i, be_i, tag_i,
    input  tag_rdata_i, valid_rdata_i, data_rdata_i,
    output gnt_o, req_o, addr_o, wdata_o, we_o, be_o,
    output rvalid_o, hit_way_o, hit_o, hit_idx_o, rdata_o, multi_hit_o, multi_hit_cnt_o
  );

  modport master (
    output req_i, addr_i, wdata_i, we_i, be_i, tag_i,
    output tag_rdata_i, valid_rdata_i, data_rdata_i,
    input  gnt_o, req_o, addr_o, wdata_o, we_o, be_o,
    input  rvalid_o, hit_way_o, hit_o, hit_idx_o, rdata_o, multi_hit_o, multi_hit_cnt_o
  );
endinterface

// File: rtl/tag_cmp_arb.sv
// rtl/tag_cmp_arb.sv - port arbiter plus one-cycle-late tag compare across all cache ways
module tag_cmp_arb #(
  parameter int NR_PORTS   = 3,
  parameter int NR_WAYS    = 8,
  parameter int ADDR_WIDTH = 64,
  parameter int TAG_WIDTH  = 44,
  parameter int DATA_WIDTH = 128,
  parameter int BE_WIDTH   = 16,
  parameter int RR_MODE    = 0,
  parameter int CNT_WIDTH  = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  tag_cmp_arb_if.slave  bus
);
  localparam int PTR_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int IDX_W = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;

  logic [PTR_W-1:0]     r_rr_ptr;
  logic [NR_PORTS-1:0]  r_id_q;
  logic                 r_vld_q;
  logic                 r_we_q;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic [NR_PORTS-1:0]  w_elig;
  logic [NR_PORTS-1:0]  w_gnt;
  logic [PTR_W-1:0]     w_win;
  logic                 w_found;
  logic                 w_we_win;
  logic                 w_resp;
  logic                 w_rd;
  logic [TAG_WIDTH-1:0] w_sel_tag;
  logic [NR_WAYS-1:0]   w_hit_way;
  logic                 w_multi;

  // Clear and reset both block new grants so nothing reaches the SRAMs.
  always_comb begin : p_elig
    w_elig = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      w_elig[p] = (|bus.req_i[p]) & ~clr_i & rst_ni;
    end
  end

  always_comb begin : p_arb
    int               v_idx;
    logic [PTR_W-1:0] v_sel;
    v_idx   = 0;
    v_sel   = '0;
    w_gnt   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NR_PORTS; k++) begin
      v_idx = (RR_MODE != 0) ? int'(r_rr_ptr) + k : k;
      if (v_idx >= NR_PORTS) v_idx = v_idx - NR_PORTS;
      v_sel = PTR_W'(v_idx);
      if (!w_found && w_elig[v_sel]) begin
        w_found      = 1'b1;
        w_gnt[v_sel] = 1'b1;
        w_win        = v_sel;
      end
    end
  end

  always_comb begin : p_mux
    bus.req_o   = '0;
    bus.addr_o  = '0;
    bus.wdata_o = '0;
    bus.be_o    = '0;
    w_we_win    = 1'b0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (w_gnt[p]) begin
        bus.req_o   = bus.req_i[p];
        bus.addr_o  = bus.addr_i[p];
        bus.wdata_o = bus.wdata_i[p];
        bus.be_o    = bus.be_i[p];
        w_we_win    = bus.we_i[p];
      end
    end
  end

  assign bus.gnt_o = w_gnt;
  assign bus.we_o  = w_we_win;

  // A response is only live in the cycle after a grant and never during a clear.
  assign w_resp = r_vld_q & ~clr_i;
  assign w_rd   = w_resp & ~r_we_q;

  always_comb begin : p_sel_tag
    w_sel_tag = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (r_id_q[p]) w_sel_tag = w_sel_tag | bus.tag_i[p];
    end
  end

  always_comb begin : p_cmp
    w_hit_way = '0;
    for (int j = 0; j < NR_WAYS; j++) begin
      w_hit_way[j] = w_rd & bus.valid_rdata_i[j] & (bus.tag_rdata_i[j] == w_sel_tag);
    end
  end

  always_comb begin : p_pick
    bus.hit_idx_o = '0;
    bus.rdata_o   = '0;
    for (int j = NR_WAYS - 1; j >= 0; j--) begin
      if (w_hit_way[j]) begin
        bus.hit_idx_o = IDX_W'(j);
        bus.rdata_o   = bus.data_rdata_i[j];
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more ways hit.
  assign w_multi             = |(w_hit_way & (w_hit_way - NR_WAYS'(1)));
  assign bus.hit_way_o       = w_hit_way;
  assign bus.hit_o           = |w_hit_way;
  assign bus.multi_hit_o     = w_multi;
  assign bus.rvalid_o        = w_resp ? r_id_q : '0;
  assign bus.multi_hit_cnt_o = r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
      r_id_q   <= '0;
      r_vld_q  <= 1'b0;
      r_we_q   <= 1'b0;
      r_cnt    <= '0;
    end else if (clr_i) begin
      r_rr_ptr <= '0;
      r_id_q   <= '0;
      r_vld_q  <= 1'b0;
      r_we_q   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_found) begin
        r_rr_ptr <= (w_win == PTR_W'(NR_PORTS - 1)) ? '0 : w_win + PTR_W'(1);
        r_id_q   <= w_gnt;
        r_vld_q  <= 1'b1;
        r_we_q   <= w_we_win;
      end else begin
        r_id_q   <= '0;
        r_vld_q  <= 1'b0;
        r_we_q   <= 1'b0;
      end
      if (w_multi && (r_cnt != '1)) r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_tag_cmp_arb.sv
// tb/tb_tag_cmp_arb.sv - directed checks of fixed-priority and round-robin tag_cmp_arb instances
module tb_tag_cmp_arb;
  logic clk;
  logic rst_n;
  logic clr;

  logic [2:0][7:0]   req;
  logic [2:0][63:0]  addr;
  logic [2:0][127:0] wdata;
  logic [2:0]        we;
  logic [2:0][15:0]  be;
  logic [2:0][43:0]  tag;
  logic [7:0][43:0]  tag_rd;
  logic [7:0]        vld_rd;
  logic [7:0][127:0] data_rd;

  int errors;
  int checks;

  tag_cmp_arb_if u_if0 ();
  tag_cmp_arb_if u_if1 ();

  assign u_if0.req_i = req;           assign u_if1.req_i = req;
  assign u_if0.addr_i = addr;         assign u_if1.addr_i = addr;
  assign u_if0.wdata_i = wdata;       assign u_if1.wdata_i = wdata;
  assign u_if0.we_i = we;             assign u_if1.we_i = we;
  assign u_if0.be_i = be;             assign u_if1.be_i = be;
  assign u_if0.tag_i = tag;           assign u_if1.tag_i = tag;
  assign u_if0.tag_rdata_i = tag_rd;  assign u_if1.tag_rdata_i = tag_rd;
  assign u_if0.valid_rdata_i = vld_rd; assign u_if1.valid_rdata_i = vld_rd;
  assign u_if0.data_rdata_i = data_rd; assign u_if1.data_rdata_i = data_rd;

  tag_cmp_arb #(.RR_MODE(0)) u_dut0 (.clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus(u_if0.slave));
  tag_cmp_arb #(.RR_MODE(1)) u_dut1 (.clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .bus(u_if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_seq [4];

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    clr    = 1'b0;
    req    = '0;
    we     = '0;
    tag    = '0;
    tag_rd = '0;
    vld_rd = '0;
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    for (int p = 0; p < 3; p++) begin
      addr[p]  = 64'hA000 + 64'(p);
      wdata[p] = 128'hB000 + 128'(p);
      be[p]    = 16'h0101 << p;
    end
    for (int j = 0; j < 8; j++) begin
      data_rd[j] = {4{32'hD000_0000 + 32'(j)}};
      tag_rd[j]  = 44'h100 + 44'(j);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", u_if0.gnt_o, 0);
    check("rst_rvalid", u_if0.rvalid_o, 0);
    check("rst_req_o", u_if0.req_o, 0);
    check("rst_hit", u_if0.hit_o, 0);
    check("rst_cnt", u_if0.multi_hit_cnt_o, 0);
    rst_n = 1'b1;
    step();

    // all three ports request with distinct way masks
    req = {8'h3C, 8'hF0, 8'h0F};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("fp_gnt", u_if0.gnt_o, 3'b001);
      check("rr_gnt", u_if1.gnt_o, rr_seq[c]);
      if (c == 0) begin
        check("fp_rvalid0", u_if0.rvalid_o, 0);
        check("rr_rvalid0", u_if1.rvalid_o, 0);
      end else begin
        check("fp_rvalid", u_if0.rvalid_o, 3'b001);
        check("rr_rvalid", u_if1.rvalid_o, rr_seq[c-1]);
      end
      if (c == 1) begin
        check("fp_req_o", u_if0.req_o, 8'h0F);
        check("rr_req_o", u_if1.req_o, 8'hF0);
        check("rr_addr_o", u_if1.addr_o, 64'hA001);
        check("rr_wdata_o", u_if1.wdata_o, 128'hB001);
        check("rr_be_o", u_if1.be_o, 16'h0202);
      end
      step();
    end
    req = {8'h00, 8'h00, 8'h0F};
    @(negedge clk);
    check("rr_wrap_gnt", u_if1.gnt_o, 3'b001);
    step();
    req = '0;
    step();

    // single hit in way 5 for a read from port 1
    req[1] = 8'hFF;
    @(negedge clk);
    check("hit_gnt", u_if0.gnt_o, 3'b010);
    step();
    req     = '0;
    tag[1]  = 44'h123;
    tag_rd[5] = 44'h123;
    vld_rd  = 8'hFF;
    @(negedge clk);
    check("hit_way", u_if0.hit_way_o, 8'h20);
    check("hit_o", u_if0.hit_o, 1);
    check("hit_idx", u_if0.hit_idx_o, 5);
    check("hit_rdata", u_if0.rdata_o, data_rd[5]);
    check("hit_rvalid", u_if0.rvalid_o, 3'b010);
    check("hit_multi", u_if0.multi_hit_o, 0);
    step();
    @(negedge clk);
    check("idle_hit", u_if0.hit_o, 0);
    check("idle_rdata", u_if0.rdata_o, 0);
    step();

    // ways 2 and 6 both match port 0
    tag_rd[5] = 44'h105;
    tag_rd[2] = 44'hABC;
    tag_rd[6] = 44'hABC;
    tag[0]    = 44'hABC;
    req[0]    = 8'hFF;
    step();
    req = '0;
    @(negedge clk);
    check("mh_way", u_if0.hit_way_o, 8'h44);
    check("mh_idx", u_if0.hit_idx_o, 2);
    check("mh_flag", u_if0.multi_hit_o, 1);
    check("mh_rdata", u_if0.rdata_o, data_rd[2]);
    step();
    @(negedge clk);
    check("mh_cnt1", u_if0.multi_hit_cnt_o, 1);
    step();
    req[0] = 8'hFF;
    repeat (253) step();
    req = '0;
    step();
    @(negedge clk);
    check("mh_cnt254", u_if0.multi_hit_cnt_o, 254);
    check("mh_cnt254_rr", u_if1.multi_hit_cnt_o, 254);
    step();
    req[0] = 8'hFF;
    repeat (46) step();
    req = '0;
    step();
    @(negedge clk);
    check("mh_cnt_sat", u_if0.multi_hit_cnt_o, 255);
    step();

    // write with matching tags present
    req[0] = 8'hFF;
    we[0]  = 1'b1;
    @(negedge clk);
    check("wr_we_o", u_if0.we_o, 1);
    step();
    req = '0;
    we  = '0;
    @(negedge clk);
    check("wr_rvalid", u_if0.rvalid_o, 3'b001);
    check("wr_hit", u_if0.hit_o, 0);
    check("wr_hit_way", u_if0.hit_way_o, 0);
    check("wr_rdata", u_if0.rdata_o, 0);
    check("wr_multi", u_if0.multi_hit_o, 0);
    step();

    // matching tags but no valid bits
    req[0] = 8'hFF;
    step();
    req    = '0;
    vld_rd = 8'h00;
    @(negedge clk);
    check("inv_rvalid", u_if0.rvalid_o, 3'b001);
    check("inv_hit", u_if0.hit_o, 0);
    check("inv_rdata", u_if0.rdata_o, 0);
    step();

    // clear right after a grant to port 0
    vld_rd = 8'hFF;
    req[0] = 8'hFF;
    step();
    clr = 1'b1;
    req = {8'hFF, 8'hFF, 8'hFF};
    @(negedge clk);
    check("clr_rvalid", u_if1.rvalid_o, 0);
    check("clr_gnt", u_if1.gnt_o, 0);
    check("clr_req_o", u_if1.req_o, 0);
    check("clr_hit", u_if1.hit_o, 0);
    step();
    clr = 1'b0;
    @(negedge clk);
    check("clr_cnt", u_if1.multi_hit_cnt_o, 0);
    check("clr_rr_ptr", u_if1.gnt_o, 3'b001);
    step();
    req = '0;
    step();
    step();

    // asynchronous reset during a response cycle
    tag_rd[5] = 44'h123;
    req[1]    = 8'hFF;
    step();
    req = '0;
    check("ar_pre_rvalid", u_if0.rvalid_o, 3'b010);
    rst_n = 1'b0;
    #1;
    check("ar_rvalid", u_if0.rvalid_o, 0);
    check("ar_hit", u_if0.hit_o, 0);
    check("ar_rdata", u_if0.rdata_o, 0);
    check("ar_cnt", u_if0.multi_hit_cnt_o, 0);
    rst_n = 1'b1;
    step();
    @(negedge clk);
    check("ar_no_resp", u_if0.rvalid_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
